memory_stage_ls: RTL and testbench

- Parametrised RISC-V pipeline MEM stage sitting between the execution stage and write-back.
- Issues byte/half/word/double loads and stores to the external memory controller over a req/ack handshake, with byte enables, store-data lane replication and load sign/zero extension.
- Stalls the pipeline while an access is outstanding and flags misaligned accesses and bus timeouts.
- Registers all write-back outputs and the branch decision (PCSrc).

---
 rtl/memory_stage_ls_if.sv | 48 ++++
 rtl/memory_stage_ls.sv | 238 +++++++++++++++++++++++
 tb/tb_memory_stage_ls.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_ls_if.sv
// -----------------------------------------------------------------------------
// memory_stage_ls_if
// Bus between the MEM pipeline stage and the external memory controller.
//
// Signals:
//   mem_req                          request, held high until the access ends
//   mem_we                           1 = store, 0 = load
//   memory_addr    [XLEN-1:0]        word/doubleword aligned address
//   data_to_write  [XLEN-1:0]        store data replicated across all lanes
//   mem_be         [XLEN/8-1:0]      byte enables
//   mem_ack                          one-cycle completion pulse from controller
//   read_data_from_memory_controller load data, valid together with mem_ack
//
// Modports:
//   master  the pipeline stage (drives the request side)
//   slave   the memory controller (drives ack and load data)
// -----------------------------------------------------------------------------
interface memory_stage_ls_if #(
    parameter int XLEN = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   memory_addr;
    logic [XLEN-1:0]   data_to_write;
    logic [XLEN/8-1:0] mem_be;
    logic              mem_ack;
    logic [XLEN-1:0]   read_data_from_memory_controller;

    modport master (
        output mem_req,
        output mem_we,
        output memory_addr,
        output data_to_write,
        output mem_be,
        input  mem_ack,
        input  read_data_from_memory_controller
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  memory_addr,
        input  data_to_write,
        input  mem_be,
        output mem_ack,
        output read_data_from_memory_controller
    );
endinterface

// File: rtl/memory_stage_ls.sv
// -----------------------------------------------------------------------------
// memory_stage_ls
// RISC-V MEM stage: issues B/H/W/D loads and stores to a req/ack memory
// controller, stalls the pipeline while an access is outstanding, detects
// misaligned accesses and bus timeouts, and registers the write-back bundle
// plus the branch decision (PCSrc).
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid                       execution-stage instruction valid
//   alu_result_from_execution      effective address / ALU result
//   flag_zero_from_execution       ALU zero flag
//   add_sum_from_execution         branch target
//   read_data_2_from_execution     store data
//   immed_11_7_from_execution      destination register index
//   funct3                         access size and signedness
//   mem_read_control               load
//   mem_write_control              store (wins if both controls are high)
//   stall                          combinational; upstream holds inputs
//   bus                            memory controller interface (master side)
//   out_valid                      write-back bundle valid
//   read_data_from_memory          extended load result
//   alu_result_from_memory         registered ALU result
//   immed_11_7_from_memory         registered destination index
//   add_sum_from_memory            registered branch target
//   PCSrc                          registered branch-taken decision
//   misaligned                     access dropped because it was misaligned
//   bus_error                      access abandoned after MAX_WAIT cycles
// -----------------------------------------------------------------------------
module memory_stage_ls #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   alu_result_from_execution,
    input  logic              flag_zero_from_execution,
    input  logic [XLEN-1:0]   add_sum_from_execution,
    input  logic [XLEN-1:0]   read_data_2_from_execution,
    input  logic [REG_AW-1:0] immed_11_7_from_execution,
    input  logic [2:0]        funct3,
    input  logic              mem_read_control,
    input  logic              mem_write_control,
    input  logic              branch_control,
    output logic              stall,
    memory_stage_ls_if.master bus,
    output logic              out_valid,
    output logic [XLEN-1:0]   read_data_from_memory,
    output logic [XLEN-1:0]   alu_result_from_memory,
    output logic [REG_AW-1:0] immed_11_7_from_memory,
    output logic [XLEN-1:0]   add_sum_from_memory,
    output logic              PCSrc,
    output logic              misaligned,
    output logic              bus_error
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int BE2_W = 2 * BE_W;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    // Natural width as log2(bytes): W on RV32, D on RV64.
    localparam logic [1:0] NAT_SZ = (XLEN == 64) ? 2'd3 : 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Access size encoded as log2(bytes). WU shares the W code; on RV32 the
    // zero extension of a full word is indistinguishable from sign extension.
    function automatic logic [1:0] decode_size(input logic [2:0] f3);
        logic [1:0] sz;
        case (f3)
            3'b000, 3'b100: sz = 2'd0;
            3'b001, 3'b101: sz = 2'd1;
            3'b010, 3'b110: sz = 2'd2;
            default:        sz = NAT_SZ;
        endcase
        return sz;
    endfunction

    // Copy the low bytes of the store data into every lane so the
    // controller can take the enabled bytes straight from the bus.
    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d,
                                                   input logic [1:0]      sz);
        logic [XLEN-1:0] r;
        case (sz)
            2'd0:    r = {(XLEN/8){d[7:0]}};
            2'd1:    r = {(XLEN/16){d[15:0]}};
            2'd2:    r = {(XLEN/32){d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Shift the selected lane to the top, then back down either
    // arithmetically (sign-extend) or logically (zero-extend).
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] lane,
                                                     input logic [1:0]      sz,
                                                     input logic            uns);
        int                     sh;
        logic signed [XLEN-1:0] t;
        sh = XLEN - (8 << sz);
        t  = signed'(lane << sh);
        if (uns) return unsigned'(t) >> sh;
        else     return t >>> sh;
    endfunction

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // Fields latched when an access is issued.
    logic [1:0]        size_p1;
    logic              uns_p1;
    logic              load_p1;
    logic [OFF_W-1:0]  off_p1;
    logic [XLEN-1:0]   alu_p1;
    logic [XLEN-1:0]   target_p1;
    logic [REG_AW-1:0] rd_p1;

    logic              mem_op;
    logic              is_store;
    logic [1:0]        size_in;
    logic [OFF_W-1:0]  off_in;
    logic [OFF_W-1:0]  size_mask;
    logic              aligned;
    logic              issue;
    logic [BE2_W-1:0]  be_ones;
    logic [BE2_W-1:0]  be_wide;
    logic [XLEN-1:0]   lane;

    // ---- Stage p0: decode of the incoming instruction ----
    always_comb begin
        is_store  = mem_write_control;
        mem_op    = in_valid & (mem_read_control | mem_write_control);
        size_in   = decode_size(funct3);
        off_in    = alu_result_from_execution[OFF_W-1:0];
        size_mask = OFF_W'((4'd1 << size_in) - 4'd1);
        aligned   = (off_in & size_mask) == '0;
        issue     = (state == IDLE) & mem_op & aligned;
        be_ones   = (BE2_W'(1) << (4'd1 << size_in)) - BE2_W'(1);
        be_wide   = be_ones << off_in;
        lane      = bus.read_data_from_memory_controller >> {off_p1, 3'b000};
    end

    // The ack/timeout cycle releases stall so upstream advances in step with
    // the result being registered.
    assign stall = issue |
                   ((state == WAIT) & ~bus.mem_ack & (cnt != MAX_CNT));

    // ---- Stage p1: request issue / wait, write-back registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= IDLE;
            cnt                    <= '0;
            size_p1                <= '0;
            uns_p1                 <= 1'b0;
            load_p1                <= 1'b0;
            off_p1                 <= '0;
            alu_p1                 <= '0;
            target_p1              <= '0;
            rd_p1                  <= '0;
            bus.mem_req            <= 1'b0;
            bus.mem_we             <= 1'b0;
            bus.memory_addr        <= '0;
            bus.data_to_write      <= '0;
            bus.mem_be             <= '0;
            out_valid              <= 1'b0;
            read_data_from_memory  <= '0;
            alu_result_from_memory <= '0;
            immed_11_7_from_memory <= '0;
            add_sum_from_memory    <= '0;
            PCSrc                  <= 1'b0;
            misaligned             <= 1'b0;
            bus_error              <= 1'b0;
        end else begin
            // Status flags only live for the cycle the result is valid.
            out_valid  <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            PCSrc      <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        size_p1           <= size_in;
                        uns_p1            <= funct3[2];
                        load_p1           <= ~is_store;
                        off_p1            <= off_in;
                        alu_p1            <= alu_result_from_execution;
                        target_p1         <= add_sum_from_execution;
                        rd_p1             <= immed_11_7_from_execution;
                        bus.mem_req       <= 1'b1;
                        bus.mem_we        <= is_store;
                        bus.memory_addr   <= {alu_result_from_execution[XLEN-1:OFF_W],
                                              {OFF_W{1'b0}}};
                        bus.data_to_write <= replicate(read_data_2_from_execution, size_in);
                        bus.mem_be        <= be_wide[BE_W-1:0];
                        cnt               <= '0;
                        state             <= WAIT;
                    end else begin
                        // Bubble, non-memory op, or misaligned access dropped.
                        out_valid              <= in_valid;
                        misaligned             <= mem_op;
                        read_data_from_memory  <= '0;
                        alu_result_from_memory <= alu_result_from_execution;
                        immed_11_7_from_memory <= immed_11_7_from_execution;
                        add_sum_from_memory    <= add_sum_from_execution;
                        PCSrc                  <= in_valid & branch_control &
                                                  flag_zero_from_execution;
                    end
                end
                WAIT: begin
                    if (bus.mem_ack || cnt == MAX_CNT) begin
                        bus.mem_req            <= 1'b0;
                        state                  <= IDLE;
                        out_valid              <= 1'b1;
                        alu_result_from_memory <= alu_p1;
                        immed_11_7_from_memory <= rd_p1;
                        add_sum_from_memory    <= target_p1;
                        // Ack wins over a coincident timeout.
                        bus_error              <= ~bus.mem_ack;
                        if (bus.mem_ack && load_p1)
                            read_data_from_memory <= extend_load(lane, size_p1, uns_p1);
                        else
                            read_data_from_memory <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage_ls.sv
module tb_memory_stage_ls;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] alu_result_from_execution;
    logic        flag_zero_from_execution;
    logic [31:0] add_sum_from_execution;
    logic [31:0] read_data_2_from_execution;
    logic [4:0]  immed_11_7_from_execution;
    logic [2:0]  funct3;
    logic        mem_read_control;
    logic        mem_write_control;
    logic        branch_control;
    logic        stall;
    logic        out_valid;
    logic [31:0] read_data_from_memory;
    logic [31:0] alu_result_from_memory;
    logic [4:0]  immed_11_7_from_memory;
    logic [31:0] add_sum_from_memory;
    logic        PCSrc;
    logic        misaligned;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    memory_stage_ls_if #(.XLEN(32)) bus ();

    memory_stage_ls #(
        .XLEN(32),
        .REG_AW(5),
        .MAX_WAIT(4)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .in_valid                   (in_valid),
        .alu_result_from_execution  (alu_result_from_execution),
        .flag_zero_from_execution   (flag_zero_from_execution),
        .add_sum_from_execution     (add_sum_from_execution),
        .read_data_2_from_execution (read_data_2_from_execution),
        .immed_11_7_from_execution  (immed_11_7_from_execution),
        .funct3                     (funct3),
        .mem_read_control           (mem_read_control),
        .mem_write_control          (mem_write_control),
        .branch_control             (branch_control),
        .stall                      (stall),
        .bus                        (bus),
        .out_valid                  (out_valid),
        .read_data_from_memory      (read_data_from_memory),
        .alu_result_from_memory     (alu_result_from_memory),
        .immed_11_7_from_memory     (immed_11_7_from_memory),
        .add_sum_from_memory        (add_sum_from_memory),
        .PCSrc                      (PCSrc),
        .misaligned                 (misaligned),
        .bus_error                  (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid                   = 1'b0;
        alu_result_from_execution  = '0;
        flag_zero_from_execution   = 1'b0;
        add_sum_from_execution     = '0;
        read_data_2_from_execution = '0;
        immed_11_7_from_execution  = '0;
        funct3                     = '0;
        mem_read_control           = 1'b0;
        mem_write_control          = 1'b0;
        branch_control             = 1'b0;
    endtask

    task automatic drive_mem(input logic [31:0] addr, input logic [2:0] f3,
                             input logic ld, input logic st,
                             input logic [31:0] sdata, input logic [4:0] rd);
        in_valid                   = 1'b1;
        alu_result_from_execution  = addr;
        funct3                     = f3;
        mem_read_control           = ld;
        mem_write_control          = st;
        read_data_2_from_execution = sdata;
        immed_11_7_from_execution  = rd;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        bus.mem_ack = 1'b0;
        bus.read_data_from_memory_controller = '0;
        repeat (2) tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rdata", read_data_from_memory, 0);
        chk("rst_pcsrc", PCSrc, 0);
        rst = 1'b0;
        tick();

        // Non-memory op
        in_valid = 1'b1;
        alu_result_from_execution = 32'h0000_1234;
        immed_11_7_from_execution = 5'd5;
        #1 chk("alu_stall", stall, 0);
        tick();
        clear_inputs();
        chk("alu_out_valid", out_valid, 1);
        chk("alu_result", alu_result_from_memory, 32'h0000_1234);
        chk("alu_rd", immed_11_7_from_memory, 5);
        chk("alu_mem_req", bus.mem_req, 0);
        #1 chk("alu_stall_after", stall, 0);

        // LB at 0x103, ack in the third WAIT cycle
        drive_mem(32'h0000_0103, 3'b000, 1'b1, 1'b0, 32'h0, 5'd7);
        #1 chk("lb_stall_c0", stall, 1);
        tick();
        chk("lb_mem_req", bus.mem_req, 1);
        chk("lb_mem_we", bus.mem_we, 0);
        chk("lb_addr", bus.memory_addr, 32'h0000_0100);
        chk("lb_be", bus.mem_be, 4'b1000);
        chk("lb_out_valid_wait", out_valid, 0);
        chk("lb_stall_c1", stall, 1);
        tick();
        chk("lb_stall_c2", stall, 1);
        tick();
        bus.mem_ack = 1'b1;
        bus.read_data_from_memory_controller = 32'h80FF_0000;
        #1 chk("lb_stall_ack", stall, 0);
        tick();
        bus.mem_ack = 1'b0;
        clear_inputs();
        chk("lb_req_drop", bus.mem_req, 0);
        chk("lb_out_valid", out_valid, 1);
        chk("lb_rdata", read_data_from_memory, 32'hFFFF_FF80);
        chk("lb_alu", alu_result_from_memory, 32'h0000_0103);
        chk("lb_rd", immed_11_7_from_memory, 7);
        tick();
        chk("lb_out_valid_clr", out_valid, 0);

        // LBU at 0x103, same data
        drive_mem(32'h0000_0103, 3'b100, 1'b1, 1'b0, 32'h0, 5'd8);
        repeat (3) tick();
        bus.mem_ack = 1'b1;
        #1 chk("lbu_stall_ack", stall, 0);
        tick();
        bus.mem_ack = 1'b0;
        clear_inputs();
        chk("lbu_out_valid", out_valid, 1);
        chk("lbu_rdata", read_data_from_memory, 32'h0000_0080);

        // SH at 0x102
        drive_mem(32'h0000_0102, 3'b001, 1'b0, 1'b1, 32'h1234_ABCD, 5'd0);
        tick();
        chk("sh_mem_req", bus.mem_req, 1);
        chk("sh_mem_we", bus.mem_we, 1);
        chk("sh_be", bus.mem_be, 4'b1100);
        chk("sh_wdata", bus.data_to_write, 32'hABCD_ABCD);
        chk("sh_addr", bus.memory_addr, 32'h0000_0100);
        bus.mem_ack = 1'b1;
        bus.read_data_from_memory_controller = 32'h5555_5555;
        #1 chk("sh_stall_ack", stall, 0);
        tick();
        bus.mem_ack = 1'b0;
        clear_inputs();
        chk("sh_out_valid", out_valid, 1);
        chk("sh_rdata", read_data_from_memory, 0);
        chk("sh_req_drop", bus.mem_req, 0);

        // LW at 0x101 is misaligned
        drive_mem(32'h0000_0101, 3'b010, 1'b1, 1'b0, 32'h0, 5'd9);
        #1 chk("lw_mis_stall", stall, 0);
        tick();
        clear_inputs();
        chk("lw_mis_req", bus.mem_req, 0);
        chk("lw_mis_out_valid", out_valid, 1);
        chk("lw_mis_flag", misaligned, 1);
        chk("lw_mis_rdata", read_data_from_memory, 0);
        // Stray ack in IDLE is ignored
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("lw_mis_flag_clr", misaligned, 0);
        chk("idle_ack_out_valid", out_valid, 0);
        chk("idle_ack_req", bus.mem_req, 0);

        // Timeout: MAX_WAIT = 4, no ack
        drive_mem(32'h0000_0200, 3'b010, 1'b1, 1'b0, 32'h0, 5'd10);
        #1 chk("to_stall_idle", stall, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_stall_wait", stall, 1);
            chk("to_req_wait", bus.mem_req, 1);
        end
        tick();
        chk("to_stall_release", stall, 0);
        tick();
        clear_inputs();
        chk("to_req_drop", bus.mem_req, 0);
        chk("to_bus_error", bus_error, 1);
        chk("to_out_valid", out_valid, 1);
        chk("to_rdata", read_data_from_memory, 0);
        tick();
        chk("to_bus_error_clr", bus_error, 0);

        // Reset during WAIT
        drive_mem(32'h0000_0300, 3'b010, 1'b1, 1'b0, 32'h0, 5'd11);
        tick();
        chk("rw_req_before", bus.mem_req, 1);
        #2;
        rst = 1'b1;
        clear_inputs();
        #1;
        chk("rw_req_async", bus.mem_req, 0);
        chk("rw_out_valid", out_valid, 0);
        chk("rw_stall", stall, 0);
        chk("rw_be", bus.mem_be, 0);
        tick();
        rst = 1'b0;
        tick();
        drive_mem(32'h0000_0300, 3'b010, 1'b1, 1'b0, 32'h0, 5'd11);
        tick();
        chk("rw_lw_req", bus.mem_req, 1);
        chk("rw_lw_addr", bus.memory_addr, 32'h0000_0300);
        chk("rw_lw_be", bus.mem_be, 4'b1111);
        bus.mem_ack = 1'b1;
        bus.read_data_from_memory_controller = 32'hDEAD_BEEF;
        tick();
        bus.mem_ack = 1'b0;
        clear_inputs();
        chk("rw_lw_out_valid", out_valid, 1);
        chk("rw_lw_rdata", read_data_from_memory, 32'hDEAD_BEEF);
        chk("rw_lw_alu", alu_result_from_memory, 32'h0000_0300);

        // Branch taken / not taken
        in_valid = 1'b1;
        branch_control = 1'b1;
        flag_zero_from_execution = 1'b1;
        add_sum_from_execution = 32'h0000_2000;
        tick();
        chk("br_pcsrc", PCSrc, 1);
        chk("br_target", add_sum_from_memory, 32'h0000_2000);
        chk("br_out_valid", out_valid, 1);
        flag_zero_from_execution = 1'b0;
        tick();
        clear_inputs();
        chk("br_nt_pcsrc", PCSrc, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
